perceptron_trainer_n: RTL
=========================

Name: perceptron_trainer_n

Overview:
- Parametrised next-generation perceptron training engine: N_IN inputs, configurable data/weight widths, samples per epoch, epoch limit and learning-rate shift.
- Fetches training samples from an external sample memory, computes yin by sequential MAC, applies the perceptron update rule and repeats epochs until no update occurs or the epoch limit is reached.
- Single module with an internal controller FSM and datapath.

Parameters:
- N_IN, 4, number of inputs/weights
- DW, 7, signed input width
- WW, 14, signed weight/bias width
- NSAMP, 16, samples per epoch
- MAX_EPOCH, 32, epoch limit
- ALPHA_SH, 0, learning rate = 2^ALPHA_SH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin training, sampled in IDLE/DONE only
- rd_en  out  1  sample read strobe
- rd_addr  out  clog2(NSAMP)  sample index
- x_data  in  N_IN*DW  packed signed inputs; x[i] = bits [i*DW +: DW]; valid the cycle after rd_en
- t_data  in  2  target: 01 = +1, 11 = -1, 00/10 = skip
- w_flat  out  N_IN*WW  packed weights
- b  out  WW  bias
- yin  out  AW  last net input; AW = WW+DW+clog2(N_IN+1)
- sign_yin  out  2  01 if yin >= 0, else 11
- epoch_cnt  out  clog2(MAX_EPOCH+1)  completed epochs
- busy  out  1  high in any state other than IDLE/DONE
- ready  out  1  high in DONE
- converged  out  1  valid when ready

Behaviour:
- Reset (async, rst=0): all outputs, weights, bias, yin and counters are 0. sign_yin = 00. FSM goes to IDLE. Reset mid-operation aborts immediately with the same values.
- start=1 in IDLE or DONE:
  - Clears weights, bias, epoch_cnt, addr and converged.
  - Sets an internal upd flag to 0.
  - Goes to FETCH.
- start while busy is ignored.
- FETCH (1 cycle): rd_en=1 with rd_addr = sample index.
- LOAD (1 cycle): captures x_data and t_data; acc = sign-extended b.
- MAC (N_IN cycles): acc += w[i]*x[i] for i = 0..N_IN-1, full precision in AW bits (no overflow by construction).
- CHECK (1 cycle):
  - yin <= acc; sign_yin updated.
  - If t is skip, or sign matches t: go to NEXT.
  - Otherwise go to UPDATE.
- UPDATE (1 cycle, all weights in parallel):
  - w[i] += t*x[i]<<ALPHA_SH.
  - b += t<<ALPHA_SH.
  - Each result saturates to the signed WW range [-2^(WW-1), 2^(WW-1)-1].
  - upd flag <= 1.
- NEXT:
  - If addr < NSAMP-1: addr++ and go to FETCH.
  - Otherwise (epoch end): epoch_cnt++ and addr = 0.
    - upd=0 -> converged=1, DONE.
    - Else if new epoch_cnt == MAX_EPOCH -> converged=0, DONE.
    - Else upd=0, FETCH.
- Per-sample latency: N_IN+4 cycles without update, N_IN+5 with update.
- DONE: ready=1. Weights, bias, yin and epoch_cnt hold until the next start.
- Zero sample (all x=0) with mismatch updates only the bias.
- An epoch consisting only of skip samples converges after epoch 1.

Optional Feature:
- Macro PERCEPTRON_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [clog2(NSAMP+1)-1:0].
  - err_cnt = mismatches in the most recently completed epoch.
  - Latched at epoch end; 0 on reset and on start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Convergence: N_IN=2, DW=4, WW=8, NSAMP=4, ALPHA_SH=0; samples (1,1,+1), (1,-1,-1), (-1,1,-1), (-1,-1,-1); start -> ready with converged=1, epoch_cnt=3, w=(1,1), b=-1. After epoch 1: w=(0,0), b=-2.
- Non-separable XOR targets: same config with MAX_EPOCH=5, samples (1,1,-1), (1,-1,+1), (-1,1,+1), (-1,-1,-1) -> ready, converged=0, epoch_cnt=5.
- Saturation: WW=4, DW=4, ALPHA_SH=1, NSAMP=1, sample (7,7,-1) -> w=(-8,-8), b=-2, converged=1, epoch_cnt=2.
- Timing: check that rd_en pulses exactly N_IN+4 cycles apart without updates and N_IN+5 with an update; rd_addr wraps 3->0 at the epoch boundary.
- Reset/start: drive rst=0 during MAC -> all outputs 0 in the same cycle, rd_en=0; pulse start while busy -> no effect; sample with t=00 -> no update.
- PERCEPTRON_ERRCNT_EN defined, convergence dataset -> err_cnt=2 after epoch 1, 1 after epoch 2, 0 after epoch 3.

Source files
------------

// File: rtl/perceptron_trainer_n.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_trainer_n
// Purpose  : Perceptron training engine. Reads NSAMP samples per epoch from
//            an external sample memory and computes the net input yin with a
//            sequential multiply-accumulate. On a sign mismatch it applies the
//            saturating update w += t*x*2^ALPHA_SH, b += t*2^ALPHA_SH. Epochs
//            repeat until one epoch makes no update (converged) or MAX_EPOCH
//            epochs have been completed.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            start      - begin training (accepted in IDLE/DONE only)
//            rd_en      - sample read strobe, rd_addr - sample index
//            x_data     - packed signed inputs, valid the cycle after rd_en
//            t_data     - target: 01=+1, 11=-1, 00/10=skip
//            w_flat, b  - packed weights and bias
//            yin        - last net input; sign_yin = 01 (>=0) / 11 (<0)
//            epoch_cnt  - completed epochs
//            busy/ready - training in progress / results available
//            converged  - valid while ready
//            err_cnt    - mismatches in the last completed epoch
//                         (present only when PERCEPTRON_ERRCNT_EN is defined)
// Options  : `define PERCEPTRON_ERRCNT_EN adds the err_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_trainer_n #(
    parameter int N_IN      = 4,
    parameter int DW        = 7,
    parameter int WW        = 14,
    parameter int NSAMP     = 16,
    parameter int MAX_EPOCH = 32,
    parameter int ALPHA_SH  = 0,
    localparam int AW       = WW + DW + $clog2(N_IN + 1),
    localparam int AAW      = (NSAMP > 1) ? $clog2(NSAMP) : 1,
    localparam int EW       = $clog2(MAX_EPOCH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 rd_en,
    output logic [AAW-1:0]       rd_addr,
    input  logic [N_IN*DW-1:0]   x_data,
    input  logic [1:0]           t_data,
    output logic [N_IN*WW-1:0]   w_flat,
    output logic [WW-1:0]        b,
    output logic [AW-1:0]        yin,
    output logic [1:0]           sign_yin,
    output logic [EW-1:0]        epoch_cnt,
    output logic                 busy,
    output logic                 ready,
    output logic                 converged
`ifdef PERCEPTRON_ERRCNT_EN
    ,
    output logic [$clog2(NSAMP+1)-1:0] err_cnt
`endif
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    // Update arithmetic width: holds a weight plus a shifted input without wrap.
    localparam int SW = ((WW > DW + ALPHA_SH) ? WW : (DW + ALPHA_SH)) + 2;
    localparam logic signed [SW-1:0] C_WMAX  = SW'(2 ** (WW - 1) - 1);
    localparam logic signed [SW-1:0] C_WMIN  = SW'(-(2 ** (WW - 1)));
    localparam logic signed [SW-1:0] C_BSTEP = SW'(2 ** ALPHA_SH);
    localparam logic [IW-1:0]        C_LAST_IDX  = IW'(N_IN - 1);
    localparam logic [AAW-1:0]       C_LAST_ADDR = AAW'(NSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_MAC    = 3'd3,
        S_CHECK  = 3'd4,
        S_UPDATE = 3'd5,
        S_NEXT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [AAW-1:0]        addr_q, addr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  yin_q, yin_d;
    logic [1:0]            sign_q, sign_d;
    logic [1:0]            t_q, t_d;
    logic [EW-1:0]         epoch_q, epoch_d;
    logic                  upd_q, upd_d;
    logic                  conv_q, conv_d;
    logic signed [WW-1:0]  w_q [N_IN];
    logic signed [WW-1:0]  w_d [N_IN];
    logic signed [WW-1:0]  b_q, b_d;
    logic signed [DW-1:0]  x_q [N_IN];
    logic signed [DW-1:0]  x_d [N_IN];
    logic signed [WW+DW-1:0] prod;
    logic                  mismatch;
`ifdef PERCEPTRON_ERRCNT_EN
    logic [$clog2(NSAMP+1)-1:0] errrun_q, errrun_d;
    logic [$clog2(NSAMP+1)-1:0] errcnt_q, errcnt_d;
`endif

    function automatic logic signed [WW-1:0] sat_add(input logic signed [WW-1:0] a,
                                                     input logic signed [SW-1:0] d);
        logic signed [SW-1:0] s;
        s = SW'(a) + d;
        if (s > C_WMAX)      return WW'(C_WMAX);
        else if (s < C_WMIN) return WW'(C_WMIN);
        else                 return s[WW-1:0];
    endfunction

    // Full-precision product of the currently selected weight/input pair.
    assign prod = (WW+DW)'(w_q[idx_q]) * (WW+DW)'(x_q[idx_q]);

    // Skip targets never mismatch; otherwise t[1] is the target sign bit.
    assign mismatch = t_q[0] && (t_q[1] != acc_q[AW-1]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        yin_d   = yin_q;
        sign_d  = sign_q;
        t_d     = t_q;
        epoch_d = epoch_q;
        upd_d   = upd_q;
        conv_d  = conv_q;
        b_d     = b_q;
        for (int i = 0; i < N_IN; i++) begin
            w_d[i] = w_q[i];
            x_d[i] = x_q[i];
        end
`ifdef PERCEPTRON_ERRCNT_EN
        errrun_d = errrun_q;
        errcnt_d = errcnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < N_IN; i++) w_d[i] = '0;
                    b_d     = '0;
                    epoch_d = '0;
                    addr_d  = '0;
                    conv_d  = 1'b0;
                    upd_d   = 1'b0;
`ifdef PERCEPTRON_ERRCNT_EN
                    errrun_d = '0;
                    errcnt_d = '0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                for (int i = 0; i < N_IN; i++) x_d[i] = x_data[i*DW +: DW];
                t_d     = t_data;
                acc_d   = AW'(b_q);
                idx_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + AW'(prod);
                idx_d = idx_q + IW'(1);
                if (idx_q == C_LAST_IDX) state_d = S_CHECK;
            end
            S_CHECK: begin
                yin_d  = acc_q;
                sign_d = acc_q[AW-1] ? 2'b11 : 2'b01;
                if (mismatch) begin
                    state_d = S_UPDATE;
`ifdef PERCEPTRON_ERRCNT_EN
                    errrun_d = errrun_q + 1'b1;
`endif
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_UPDATE: begin
                // Only reached with t = +1/-1, so t[1] selects the sign of the step.
                for (int i = 0; i < N_IN; i++) begin
                    w_d[i] = sat_add(w_q[i], t_q[1] ? -(SW'(x_q[i]) <<< ALPHA_SH)
                                                    :  (SW'(x_q[i]) <<< ALPHA_SH));
                end
                b_d     = sat_add(b_q, t_q[1] ? -C_BSTEP : C_BSTEP);
                upd_d   = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (addr_q != C_LAST_ADDR) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    epoch_d = epoch_q + 1'b1;
                    addr_d  = '0;
`ifdef PERCEPTRON_ERRCNT_EN
                    errcnt_d = errrun_q;
                    errrun_d = '0;
`endif
                    if (!upd_q) begin
                        conv_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (epoch_d == EW'(MAX_EPOCH)) begin
                        conv_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        upd_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            yin_q   <= '0;
            sign_q  <= 2'b00;
            t_q     <= 2'b00;
            epoch_q <= '0;
            upd_q   <= 1'b0;
            conv_q  <= 1'b0;
            b_q     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
`ifdef PERCEPTRON_ERRCNT_EN
            errrun_q <= '0;
            errcnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            yin_q   <= yin_d;
            sign_q  <= sign_d;
            t_q     <= t_d;
            epoch_q <= epoch_d;
            upd_q   <= upd_d;
            conv_q  <= conv_d;
            b_q     <= b_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
                x_q[i] <= x_d[i];
            end
`ifdef PERCEPTRON_ERRCNT_EN
            errrun_q <= errrun_d;
            errcnt_q <= errcnt_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_pack
            assign w_flat[gi*WW +: WW] = w_q[gi];
        end
    endgenerate

    assign rd_en     = (state_q == S_FETCH);
    assign rd_addr   = addr_q;
    assign b         = b_q;
    assign yin       = yin_q;
    assign sign_yin  = sign_q;
    assign epoch_cnt = epoch_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ready     = (state_q == S_DONE);
    assign converged = conv_q;
`ifdef PERCEPTRON_ERRCNT_EN
    assign err_cnt   = errcnt_q;
`endif

endmodule
`default_nettype wire
